// File: rtl/rename_if.sv
// Handshake and commit bundle between decode, the rename stage and dispatch.
// The slave modport is the rename stage's own view of the bundle.
interface rename_if #(
  parameter int AW = 5,
  parameter int PW = 6
);
  logic          in_valid;
  logic          in_ready;
  logic [6:0]    in_opcode;
  logic [AW-1:0] in_rs1;
  logic [AW-1:0] in_rs2;
  logic [AW-1:0] in_rd;
  logic [31:0]   in_instr;

  logic          out_valid;
  logic          out_ready;
  logic [6:0]    out_opcode;
  logic [PW-1:0] out_ps1;
  logic [PW-1:0] out_ps2;
  logic [PW-1:0] out_pd;
  logic [PW-1:0] out_old_pd;
  logic [31:0]   out_instr;

  logic          commit_valid;
  logic [PW-1:0] commit_pd;
  logic [PW:0]   free_count;
  logic          overflow_err;

  modport master (
    output in_valid, in_opcode, in_rs1, in_rs2, in_rd, in_instr,
    output out_ready, commit_valid, commit_pd,
    input  in_ready, out_valid, out_opcode, out_ps1, out_ps2, out_pd,
    input  out_old_pd, out_instr, free_count, overflow_err
  );

  modport slave (
    input  in_valid, in_opcode, in_rs1, in_rs2, in_rd, in_instr,
    input  out_ready, commit_valid, commit_pd,
    output in_ready, out_valid, out_opcode, out_ps1, out_ps2, out_pd,
    output out_old_pd, out_instr, free_count, overflow_err
  );
endinterface

// File: rtl/rename_unit.sv
// Register rename stage: RAT lookup for sources, free-list allocation for the
// destination, and a commit port that returns retired mappings to the free list.
module rename_unit #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64
) (
  input  logic     clk,
  input  logic     rst_n,
  rename_if.slave  bus
);
  localparam int AW       = $clog2(ARCH_REGS);
  localparam int PW       = $clog2(PHYS_REGS);
  localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;
  localparam int FLW      = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;

  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [PW-1:0]  rat       [ARCH_REGS];
  logic [PW-1:0]  free_list [FL_DEPTH];
  logic [FLW-1:0] head;
  logic [FLW-1:0] tail;
  logic [PW:0]    count;

  logic          out_valid_q;
  logic [6:0]    out_opcode_q;
  logic [PW-1:0] out_ps1_q;
  logic [PW-1:0] out_ps2_q;
  logic [PW-1:0] out_pd_q;
  logic [PW-1:0] out_old_pd_q;
  logic [31:0]   out_instr_q;
  logic          overflow_q;

  logic needs_alloc;
  logic in_ready;
  logic accept;
  logic alloc;
  logic commit_req;
  logic fl_has_room;
  logic commit_ok;
  logic commit_drop;

  function automatic logic [FLW-1:0] wrap_inc(input logic [FLW-1:0] p);
    return (p == FLW'(FL_DEPTH - 1)) ? '0 : p + FLW'(1);
  endfunction

  // x0 writes, stores and branches produce no destination and take no register.
  assign needs_alloc = (bus.in_rd != AW'(0)) &&
                       (bus.in_opcode != OP_STORE) &&
                       (bus.in_opcode != OP_BRANCH);
  assign in_ready    = (!out_valid_q || bus.out_ready) &&
                       (!needs_alloc || count != '0);
  assign accept      = bus.in_valid && in_ready;
  assign alloc       = accept && needs_alloc;

  // A commit into a full list is still legal when an allocation frees a slot this cycle.
  assign commit_req  = bus.commit_valid && (bus.commit_pd != '0);
  assign fl_has_room = count < (PW+1)'(FL_DEPTH);
  assign commit_ok   = commit_req && (fl_has_room || alloc);
  assign commit_drop = commit_req && !fl_has_room && !alloc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ARCH_REGS; i++) rat[i] <= PW'(i);
    end else if (alloc) begin
      rat[bus.in_rd] <= free_list[head];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FL_DEPTH; i++) free_list[i] <= PW'(ARCH_REGS + i);
    end else if (commit_ok) begin
      free_list[tail] <= bus.commit_pd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= (PW+1)'(FL_DEPTH);
    end else begin
      if (alloc)     head <= wrap_inc(head);
      if (commit_ok) tail <= wrap_inc(tail);
      case ({alloc, commit_ok})
        2'b10:   count <= count - (PW+1)'(1);
        2'b01:   count <= count + (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sources read the RAT before this cycle's destination write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_opcode_q <= '0;
      out_ps1_q    <= '0;
      out_ps2_q    <= '0;
      out_pd_q     <= '0;
      out_old_pd_q <= '0;
      out_instr_q  <= '0;
    end else if (accept) begin
      out_valid_q  <= 1'b1;
      out_opcode_q <= bus.in_opcode;
      out_ps1_q    <= rat[bus.in_rs1];
      out_ps2_q    <= rat[bus.in_rs2];
      out_pd_q     <= needs_alloc ? free_list[head] : '0;
      out_old_pd_q <= needs_alloc ? rat[bus.in_rd] : '0;
      out_instr_q  <= bus.in_instr;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           overflow_q <= 1'b0;
    else if (commit_drop) overflow_q <= 1'b1;
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_opcode   = out_opcode_q;
  assign bus.out_ps1      = out_ps1_q;
  assign bus.out_ps2      = out_ps2_q;
  assign bus.out_pd       = out_pd_q;
  assign bus.out_old_pd   = out_old_pd_q;
  assign bus.out_instr    = out_instr_q;
  assign bus.free_count   = count;
  assign bus.overflow_err = overflow_q;
endmodule

// File: tb/tb_rename_unit.sv
// Directed bench for rename_unit: allocation, stalls, free-list wrap,
// commit/overflow handling and asynchronous reset.
module tb_rename_unit;
  localparam logic [6:0] OP_ADD    = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;
  logic [31:0] exp_instr;

  rename_if #(.AW(5), .PW(6)) bus ();

  rename_unit #(.ARCH_REGS(32), .PHYS_REGS(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_total++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d want %0d", tag, actual, expected);
    end
  endtask

  // Presents one instruction, confirms it is accepted, and clocks it in.
  task automatic applyStimulus(input string tag, input logic [6:0] op,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd);
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_rd     = rd;
    bus.in_instr  = {7'b0, rs2, rs1, 3'b0, rd, op};
    bus.out_ready = 1'b1;
    #1;
    checkOutput({tag, ".rdy"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic expectOut(input string tag, input int ps1, input int ps2,
                           input int pd, input int old_pd, input int fc);
    checkOutput({tag, ".vld"}, 32'(bus.out_valid), 32'd1);
    checkOutput({tag, ".ps1"}, 32'(bus.out_ps1), 32'(ps1));
    checkOutput({tag, ".ps2"}, 32'(bus.out_ps2), 32'(ps2));
    checkOutput({tag, ".pd"}, 32'(bus.out_pd), 32'(pd));
    checkOutput({tag, ".old"}, 32'(bus.out_old_pd), 32'(old_pd));
    checkOutput({tag, ".fc"}, 32'(bus.free_count), 32'(fc));
  endtask

  task automatic commitReg(input logic [5:0] pd);
    bus.commit_valid = 1'b1;
    bus.commit_pd    = pd;
    @(posedge clk);
    #1;
    bus.commit_valid = 1'b0;
    bus.commit_pd    = '0;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n            = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_opcode    = '0;
    bus.in_rs1       = '0;
    bus.in_rs2       = '0;
    bus.in_rd        = '0;
    bus.in_instr     = '0;
    bus.out_ready    = 1'b1;
    bus.commit_valid = 1'b0;
    bus.commit_pd    = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.vld", 32'(bus.out_valid), 32'd0);
    checkOutput("rst.fc", 32'(bus.free_count), 32'd32);
    checkOutput("rst.ovf", 32'(bus.overflow_err), 32'd0);
    checkOutput("rst.pd", 32'(bus.out_pd), 32'd0);
    checkOutput("rst.rdy", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    #1;

    $display("[TB] basic allocation");
    applyStimulus("add1", OP_ADD, 5'd1, 5'd2, 5'd5);
    exp_instr = {7'b0, 5'd2, 5'd1, 3'b0, 5'd5, OP_ADD};
    expectOut("add1", 1, 2, 32, 5, 31);
    checkOutput("add1.op", 32'(bus.out_opcode), 32'(OP_ADD));
    checkOutput("add1.instr", bus.out_instr, exp_instr);

    $display("[TB] back-to-back dependency");
    applyStimulus("dep1", OP_ADD, 5'd5, 5'd5, 5'd5);
    expectOut("dep1", 32, 32, 33, 32, 30);
    applyStimulus("dep2", OP_ADD, 5'd5, 5'd5, 5'd5);
    expectOut("dep2", 33, 33, 34, 33, 29);

    $display("[TB] non-allocating instructions");
    applyStimulus("sw", OP_STORE, 5'd4, 5'd5, 5'd3);
    expectOut("sw", 4, 34, 0, 0, 29);
    applyStimulus("addx0", OP_ADD, 5'd1, 5'd2, 5'd0);
    expectOut("addx0", 1, 2, 0, 0, 29);
    applyStimulus("beq", OP_BRANCH, 5'd3, 5'd5, 5'd9);
    expectOut("beq", 3, 34, 0, 0, 29);

    $display("[TB] drain free list");
    for (int i = 0; i < 29; i++) begin
      applyStimulus("fill", OP_ADD, 5'd0, 5'd0, 5'd10);
      checkOutput("fill.pd", 32'(bus.out_pd), 32'(35 + i));
      checkOutput("fill.old", 32'(bus.out_old_pd), (i == 0) ? 32'd10 : 32'(34 + i));
    end
    checkOutput("empty.fc", 32'(bus.free_count), 32'd0);
    bus.in_valid  = 1'b1;
    bus.in_opcode = OP_ADD;
    bus.in_rd     = 5'd11;
    #1;
    checkOutput("empty.rdy_alloc", 32'(bus.in_ready), 32'd0);
    bus.in_opcode = OP_STORE;
    #1;
    checkOutput("empty.rdy_store", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0;

    commitReg(6'd5);
    checkOutput("refill.fc", 32'(bus.free_count), 32'd1);
    applyStimulus("wrap", OP_ADD, 5'd1, 5'd2, 5'd11);
    expectOut("wrap", 1, 2, 5, 11, 0);

    $display("[TB] output stall");
    commitReg(6'd32);
    commitReg(6'd33);
    checkOutput("stall.fc0", 32'(bus.free_count), 32'd2);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_opcode = OP_ADD;
    bus.in_rs1    = 5'd1;
    bus.in_rs2    = 5'd2;
    bus.in_rd     = 5'd12;
    @(posedge clk);
    #1;
    bus.in_rd = 5'd13;
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput("stall.rdy", 32'(bus.in_ready), 32'd0);
      expectOut("stall", 1, 2, 32, 12, 1);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    #1;
    checkOutput("release.rdy", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    expectOut("release", 1, 2, 33, 13, 0);

    $display("[TB] asynchronous reset mid-stream");
    rst_n = 1'b0;
    #1;
    checkOutput("arst.vld", 32'(bus.out_valid), 32'd0);
    checkOutput("arst.fc", 32'(bus.free_count), 32'd32);
    checkOutput("arst.pd", 32'(bus.out_pd), 32'd0);
    rst_n = 1'b1;
    #1;
    applyStimulus("post_rst", OP_ADD, 5'd8, 5'd7, 5'd9);
    expectOut("post_rst", 8, 7, 32, 9, 31);

    $display("[TB] commit paths");
    bus.commit_valid = 1'b1;
    bus.commit_pd    = 6'd7;
    applyStimulus("alloc_commit", OP_ADD, 5'd1, 5'd2, 5'd8);
    bus.commit_valid = 1'b0;
    bus.commit_pd    = '0;
    expectOut("alloc_commit", 1, 2, 33, 8, 31);
    commitReg(6'd9);
    checkOutput("full.fc", 32'(bus.free_count), 32'd32);
    commitReg(6'd0);
    checkOutput("x0.ovf", 32'(bus.overflow_err), 32'd0);
    checkOutput("x0.fc", 32'(bus.free_count), 32'd32);
    commitReg(6'd10);
    checkOutput("ovf.flag", 32'(bus.overflow_err), 32'd1);
    checkOutput("ovf.fc", 32'(bus.free_count), 32'd32);
    @(posedge clk);
    #1;
    checkOutput("ovf.sticky", 32'(bus.overflow_err), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
